wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL take parameter xlen, default 32 from cpu_parameters: register data width.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports alu_valid in 1, alu_result in xlen, alu_rd in 5: ALU write-back request (result_valid/result/rd_o of ALU).
REQ-005 SHALL have port alu_ok  out  1  accept for ALU; feeds ALU ok_i.
REQ-006 SHALL have ports lsu_valid in 1, lsu_result in xlen, lsu_rd in 5: load/store unit write-back request.
REQ-007 SHALL have port lsu_ok  out  1  accept for LSU.
REQ-008 SHALL have port hold  in  1  stall; blocks new acceptance.
REQ-009 SHALL have ports rf_we out 1, rf_waddr out 5, rf_wdata out xlen: register file write port.
REQ-010 SHALL have ports clr_valid out 1, clr_rd out 5: scoreboard busy-clear to register manager.
REQ-011 SHALL have port retired  out  32  count of accepted write-backs.

Function
REQ-012 SHALL define transfer on a source as valid=1 and ok=1 in the same cycle.
REQ-013 SHALL drive ok combinationally from valid, hold and the round-robin pointer; ok=0 whenever valid=0 or hold=1.
REQ-014 SHALL grant the sole requester when exactly one valid is high and hold=0.
REQ-015 SHALL grant on simultaneous valid per 1-bit pointer last_lsu: last_lsu=0 grants LSU, else ALU.
REQ-016 SHALL set last_lsu to the winner's identity (1=LSU) after every transfer; unchanged otherwise.
REQ-017 SHALL accept at most one source per cycle; the loser's ok=0 and its valid/data must stay stable until accepted.
REQ-018 SHALL register the accepted rd/result into a one-entry output stage; latency from transfer to rf_we exactly 1 cycle.
REQ-019 SHALL drive rf_we=1 for one cycle per transfer with rd!=0; rd=0 transfers SHALL be accepted with rf_we=0.
REQ-020 SHALL drive clr_valid=1, clr_rd=rd in the same cycle as rf_we, including rd=0 (clr_rd=0).
REQ-021 SHALL hold rf_waddr/rf_wdata/clr_rd at last value when not writing; rf_we/clr_valid low.
REQ-022 SHALL support back-to-back transfers every cycle (full throughput, no bubble).
REQ-023 SHALL increment retired by 1 per transfer, wrapping 0xFFFFFFFF -> 0.
REQ-024 SHALL, when hold=1, accept nothing and leave last_lsu unchanged; an output-stage write already registered completes the next cycle.

Reset
REQ-025 SHALL on rst=1 set rf_we=0, clr_valid=0, rf_waddr=0, rf_wdata=0, clr_rd=0, retired=0, last_lsu=0.
REQ-026 SHALL drive alu_ok=lsu_ok=0 while rst=1; a transfer pending in the output stage SHALL be discarded.
REQ-027 SHALL accept normally on the first cycle after rst deasserts.

Structure
REQ-028 SHALL take xlen and register-index width from cpu_parameters; wb-request struct {valid, rd, result} SHALL live there.
REQ-029 SHALL contain one sub-module rr_arbiter2 (2-way round-robin grant, pointer state); output stage and counter inline.

Verification
REQ-030 Single ALU: alu_valid=1, rd=5, result=0xDEADBEEF -> alu_ok=1 same cycle; next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF, clr_valid=1, clr_rd=5; retired=1.
REQ-031 Contention after reset: both valid (ALU rd=1, LSU rd=2) for 2 cycles -> cycle0 lsu_ok=1, cycle1 alu_ok=1; writes rd2 then rd1 on consecutive cycles.
REQ-032 rd=0: lsu_valid=1, rd=0, result=0x12 -> lsu_ok=1; next cycle rf_we=0, clr_valid=1, clr_rd=0; retired increments.
REQ-033 Hold: hold=1 with alu_valid=1 for 3 cycles -> alu_ok=0, no writes; hold drops -> accepted that cycle, write next cycle.
REQ-034 Wrap/reset: retired forced to 0xFFFFFFFF, one transfer -> 0; rst=1 same cycle as transfer -> no rf_we next cycle, retired=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared CPU parameters for the write-back arbiter: data width, register-index
// width and the write-back request record.
package wb_arbiter_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      result;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus between the ALU/LSU producers, the register file and the
// register manager; the arbiter sits on the slave side.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int xlen = XLEN
);

  logic                 alu_valid;
  logic [xlen-1:0]      alu_result;
  logic [REG_IDX_W-1:0] alu_rd;
  logic                 alu_ok;
  logic                 lsu_valid;
  logic [xlen-1:0]      lsu_result;
  logic [REG_IDX_W-1:0] lsu_rd;
  logic                 lsu_ok;
  logic                 hold;
  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_waddr;
  logic [xlen-1:0]      rf_wdata;
  logic                 clr_valid;
  logic [REG_IDX_W-1:0] clr_rd;
  logic [31:0]          retired;

  modport master (
    output alu_valid, alu_result, alu_rd, lsu_valid, lsu_result, lsu_rd, hold,
    input  alu_ok, lsu_ok, rf_we, rf_waddr, rf_wdata, clr_valid, clr_rd, retired
  );

  modport slave (
    input  alu_valid, alu_result, alu_rd, lsu_valid, lsu_result, lsu_rd, hold,
    output alu_ok, lsu_ok, rf_we, rf_waddr, rf_wdata, clr_valid, clr_rd, retired
  );

endinterface

// File: rtl/wb_arbiter_rr_arbiter2.sv
// Two-way round-robin grant between ALU and LSU. The pointer remembers the
// last winner so a simultaneous request goes to the other source.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_lsu,
  input  logic hold,
  output logic grant_alu,
  output logic grant_lsu
);

  logic last_lsu_reg;
  logic last_lsu_next;

  always_comb begin
    grant_alu     = 1'b0;
    grant_lsu     = 1'b0;
    last_lsu_next = last_lsu_reg;
    if (!rst && !hold) begin
      // On contention the source that did not win last time goes first.
      grant_lsu = req_lsu && (!req_alu || !last_lsu_reg);
      grant_alu = req_alu && (!req_lsu ||  last_lsu_reg);
    end
    if (grant_lsu) begin
      last_lsu_next = 1'b1;
    end else if (grant_alu) begin
      last_lsu_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu_reg <= 1'b0;
    end else begin
      last_lsu_reg <= last_lsu_next;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks one of ALU/LSU per cycle, registers the winner into
// a one-entry stage driving the register file and busy-clear, counts retirements.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int xlen = XLEN
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);

  logic                 grant_alu;
  logic                 grant_lsu;
  wb_req_t              sel_req;

  logic                 rf_we_reg;
  logic [REG_IDX_W-1:0] rf_waddr_reg;
  logic [xlen-1:0]      rf_wdata_reg;
  logic                 clr_valid_reg;
  logic [REG_IDX_W-1:0] clr_rd_reg;
  logic [31:0]          retired_reg;

  rr_arbiter2 u_rr_arbiter2 (
    .clk       (clk),
    .rst       (rst),
    .req_alu   (bus.alu_valid),
    .req_lsu   (bus.lsu_valid),
    .hold      (bus.hold),
    .grant_alu (grant_alu),
    .grant_lsu (grant_lsu)
  );

  assign bus.alu_ok = grant_alu;
  assign bus.lsu_ok = grant_lsu;

  always_comb begin
    sel_req = '0;
    if (grant_lsu) begin
      sel_req = '{valid: 1'b1, rd: bus.lsu_rd, result: XLEN'(bus.lsu_result)};
    end else if (grant_alu) begin
      sel_req = '{valid: 1'b1, rd: bus.alu_rd, result: XLEN'(bus.alu_result)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg     <= 1'b0;
      rf_waddr_reg  <= '0;
      rf_wdata_reg  <= '0;
      clr_valid_reg <= 1'b0;
      clr_rd_reg    <= '0;
      retired_reg   <= '0;
    end else begin
      // x0 writes are swallowed, but the busy-clear still fires for them.
      rf_we_reg     <= sel_req.valid && (sel_req.rd != '0);
      clr_valid_reg <= sel_req.valid;
      if (sel_req.valid) begin
        rf_waddr_reg <= sel_req.rd;
        rf_wdata_reg <= xlen'(sel_req.result);
        clr_rd_reg   <= sel_req.rd;
        retired_reg  <= retired_reg + 32'd1;
      end
    end
  end

  assign bus.rf_we     = rf_we_reg;
  assign bus.rf_waddr  = rf_waddr_reg;
  assign bus.rf_wdata  = rf_wdata_reg;
  assign bus.clr_valid = clr_valid_reg;
  assign bus.clr_rd    = clr_rd_reg;
  assign bus.retired   = retired_reg;

endmodule
